// File: rtl/otp_auth_ctrl.sv
// OTP session controller: latches a generated OTP, assembles a 4-digit serial
// entry, compares on submit and tracks wrong attempts, lockout, unlock hold and expiry.
module otp_auth_ctrl #(
  parameter int unsigned EXPIRE_CYCLES = 1000,
  parameter int unsigned UNLOCK_CYCLES = 500,
  parameter int unsigned LOCK_CYCLES   = 2000
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        gen,
  input  logic [15:0] otp_in,
  input  logic        digit_vld,
  input  logic [3:0]  digit,
  input  logic        submit,
  output logic [15:0] user_otp,
  output logic [15:0] lfsr_otp,
  output logic        unlock,
  output logic        lock,
  output logic        expire,
  output logic [1:0]  wrng_att,
  output logic        busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ACTIVE,
    S_UNLOCKED,
    S_LOCKED,
    S_EXPIRED
  } state_t;

  localparam logic [23:0] EXP_LOAD = 24'(EXPIRE_CYCLES - 1);
  localparam logic [23:0] UNL_LOAD = 24'(UNLOCK_CYCLES - 1);
  localparam logic [23:0] LCK_LOAD = 24'(LOCK_CYCLES - 1);

  state_t      state;
  logic [2:0]  dcnt;
  logic [23:0] timer;

  logic        start;
  logic        timer_zero;
  logic [23:0] timer_dec;
  logic        entry_full;
  logic        entry_match;
  logic [1:0]  att_inc;

  // gen opens a new session from every state except LOCKED
  assign start       = gen && (state inside {S_IDLE, S_ACTIVE, S_UNLOCKED, S_EXPIRED});
  assign timer_zero  = (timer == '0);
  // Holds at zero so a mismatch on the last ACTIVE cycle still expires on the next one
  assign timer_dec   = timer_zero ? '0 : timer - 24'd1;
  assign entry_full  = (dcnt == 3'd4);
  assign entry_match = (user_otp == lfsr_otp);
  assign att_inc     = wrng_att + 2'd1;

  function automatic logic [3:0] flags_of(input state_t s);
    return {s != S_IDLE, s == S_UNLOCKED, s == S_LOCKED, s == S_EXPIRED};
  endfunction

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state    <= S_IDLE;
      dcnt     <= '0;
      timer    <= '0;
      user_otp <= '0;
      lfsr_otp <= '0;
      wrng_att <= '0;
      {busy, unlock, lock, expire} <= '0;
    end else if (start) begin
      state    <= S_ACTIVE;
      lfsr_otp <= otp_in;
      user_otp <= '0;
      dcnt     <= '0;
      timer    <= EXP_LOAD;
      {busy, unlock, lock, expire} <= flags_of(S_ACTIVE);
    end else begin
      case (state)
        S_ACTIVE: begin
          timer <= timer_dec;
          if (submit && entry_full) begin
            if (entry_match) begin
              state    <= S_UNLOCKED;
              wrng_att <= '0;
              timer    <= UNL_LOAD;
              {busy, unlock, lock, expire} <= flags_of(S_UNLOCKED);
            end else begin
              wrng_att <= att_inc;
              user_otp <= '0;
              dcnt     <= '0;
              if (att_inc == 2'd3) begin
                state <= S_LOCKED;
                timer <= LCK_LOAD;
                {busy, unlock, lock, expire} <= flags_of(S_LOCKED);
              end
            end
          end else begin
            if (digit_vld && !submit) begin
              user_otp <= {user_otp[11:0], digit};
              if (!entry_full) dcnt <= dcnt + 3'd1;
            end
            if (timer_zero) begin
              state <= S_EXPIRED;
              {busy, unlock, lock, expire} <= flags_of(S_EXPIRED);
            end
          end
        end
        S_UNLOCKED: begin
          if (timer_zero) begin
            state    <= S_IDLE;
            user_otp <= '0;
            lfsr_otp <= '0;
            {busy, unlock, lock, expire} <= flags_of(S_IDLE);
          end else begin
            timer <= timer_dec;
          end
        end
        S_LOCKED: begin
          if (timer_zero) begin
            state    <= S_IDLE;
            wrng_att <= '0;
            user_otp <= '0;
            lfsr_otp <= '0;
            {busy, unlock, lock, expire} <= flags_of(S_IDLE);
          end else begin
            timer <= timer_dec;
          end
        end
        S_IDLE, S_EXPIRED: ;
        default: begin
          state <= S_IDLE;
          {busy, unlock, lock, expire} <= flags_of(S_IDLE);
        end
      endcase
    end
  end

endmodule

// File: tb/tb_otp_auth_ctrl.sv
// Self-checking bench for otp_auth_ctrl: directed vector table, hand sequences
// for lockout/expiry/simultaneous events/reset, then randomized traffic vs. a deadline-based model.
module tb_otp_auth_ctrl;

  localparam int unsigned EXP_C = 20;
  localparam int unsigned UNL_C = 5;
  localparam int unsigned LCK_C = 8;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        gen = 1'b0;
  logic [15:0] otp_in = '0;
  logic        digit_vld = 1'b0;
  logic [3:0]  digit = '0;
  logic        submit = 1'b0;
  logic [15:0] user_otp, lfsr_otp;
  logic        unlock, lock, expire, busy;
  logic [1:0]  wrng_att;

  always #5 clk = ~clk;

  otp_auth_ctrl #(
    .EXPIRE_CYCLES(EXP_C),
    .UNLOCK_CYCLES(UNL_C),
    .LOCK_CYCLES  (LCK_C)
  ) dut (
    .clk      (clk),
    .rstn     (rstn),
    .gen      (gen),
    .otp_in   (otp_in),
    .digit_vld(digit_vld),
    .digit    (digit),
    .submit   (submit),
    .user_otp (user_otp),
    .lfsr_otp (lfsr_otp),
    .unlock   (unlock),
    .lock     (lock),
    .expire   (expire),
    .wrng_att (wrng_att),
    .busy     (busy)
  );

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  // Reference model: session mode plus an absolute deadline cycle
  typedef enum {M_IDLE, M_ACT, M_UNL, M_LCK, M_EXP} mmode_t;
  mmode_t      m_mode = M_IDLE;
  logic [15:0] m_user = '0, m_lfsr = '0;
  int          m_att = 0, m_n = 0, m_end = 0;

  task automatic model_edge();
    if (!rstn) begin
      m_mode = M_IDLE; m_user = '0; m_lfsr = '0; m_att = 0; m_n = 0;
    end else if (gen && m_mode != M_LCK) begin
      m_mode = M_ACT; m_lfsr = otp_in; m_user = '0; m_n = 0; m_end = cyc + EXP_C;
    end else begin
      case (m_mode)
        M_ACT: begin
          if (submit && m_n == 4) begin
            if (m_user == m_lfsr) begin
              m_mode = M_UNL; m_att = 0; m_end = cyc + UNL_C;
            end else begin
              m_att++; m_user = '0; m_n = 0;
              if (m_att == 3) begin m_mode = M_LCK; m_end = cyc + LCK_C; end
            end
          end else begin
            if (digit_vld && !submit) begin
              m_user = {m_user[11:0], digit};
              if (m_n < 4) m_n++;
            end
            if (cyc >= m_end) m_mode = M_EXP;
          end
        end
        M_UNL: if (cyc >= m_end) begin m_mode = M_IDLE; m_user = '0; m_lfsr = '0; end
        M_LCK: if (cyc >= m_end) begin m_mode = M_IDLE; m_user = '0; m_lfsr = '0; m_att = 0; end
        default: ;
      endcase
    end
  endtask

  function automatic logic [37:0] dut_vec();
    return {user_otp, lfsr_otp, unlock, lock, expire, wrng_att, busy};
  endfunction

  function automatic logic [37:0] model_vec();
    return {m_user, m_lfsr, m_mode == M_UNL, m_mode == M_LCK, m_mode == M_EXP,
            2'(m_att), m_mode != M_IDLE};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    cyc++;
    #1;
    check("model", 64'(dut_vec()), 64'(model_vec()));
    gen = 1'b0; digit_vld = 1'b0; submit = 1'b0;
  endtask

  task automatic enter(input logic [15:0] v);
    for (int i = 3; i >= 0; i--) begin
      digit_vld = 1'b1; digit = v[4*i +: 4];
      tick();
    end
  endtask

  typedef struct {
    logic        g;
    logic [15:0] otp;
    logic        dv;
    logic [3:0]  d;
    logic        sub;
    logic [15:0] e_user;
    logic [15:0] e_lfsr;
    logic [5:0]  e_flags;  // {unlock, lock, expire, wrng_att[1:0], busy}
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic g, input logic [15:0] o, input logic dv, input logic [3:0] d,
                     input logic s, input logic [15:0] eu, input logic [15:0] el,
                     input logic [5:0] fl);
    vec_t v;
    v.g = g; v.otp = o; v.dv = dv; v.d = d; v.sub = s;
    v.e_user = eu; v.e_lfsr = el; v.e_flags = fl;
    tbl.push_back(v);
  endtask

  initial begin
    // Correct entry, unlock hold, return to idle
    add(1, 16'h3A7C, 0, 4'h0, 0, 16'h0000, 16'h3A7C, 6'b000_00_1);
    add(0, 16'h0000, 1, 4'h3, 0, 16'h0003, 16'h3A7C, 6'b000_00_1);
    add(0, 16'h0000, 1, 4'hA, 0, 16'h003A, 16'h3A7C, 6'b000_00_1);
    add(0, 16'h0000, 1, 4'h7, 0, 16'h03A7, 16'h3A7C, 6'b000_00_1);
    add(0, 16'h0000, 1, 4'hC, 0, 16'h3A7C, 16'h3A7C, 6'b000_00_1);
    add(0, 16'h0000, 0, 4'h0, 1, 16'h3A7C, 16'h3A7C, 6'b100_00_1);
    add(0, 16'h0000, 0, 4'h0, 0, 16'h3A7C, 16'h3A7C, 6'b100_00_1);
    add(0, 16'h0000, 1, 4'hF, 1, 16'h3A7C, 16'h3A7C, 6'b100_00_1);
    add(0, 16'h0000, 0, 4'h0, 0, 16'h3A7C, 16'h3A7C, 6'b100_00_1);
    add(0, 16'h0000, 0, 4'h0, 0, 16'h3A7C, 16'h3A7C, 6'b100_00_1);
    add(0, 16'h0000, 0, 4'h0, 0, 16'h0000, 16'h0000, 6'b000_00_0);
    // Idle ignores digits/submit; partial submit, dropped digit, overflow, mismatch
    add(0, 16'h0000, 1, 4'h9, 1, 16'h0000, 16'h0000, 6'b000_00_0);
    add(1, 16'h1234, 0, 4'h0, 0, 16'h0000, 16'h1234, 6'b000_00_1);
    add(0, 16'h0000, 1, 4'h1, 0, 16'h0001, 16'h1234, 6'b000_00_1);
    add(0, 16'h0000, 1, 4'h2, 0, 16'h0012, 16'h1234, 6'b000_00_1);
    add(0, 16'h0000, 1, 4'h3, 0, 16'h0123, 16'h1234, 6'b000_00_1);
    add(0, 16'h0000, 0, 4'h0, 1, 16'h0123, 16'h1234, 6'b000_00_1);
    add(0, 16'h0000, 1, 4'h4, 1, 16'h0123, 16'h1234, 6'b000_00_1);
    add(0, 16'h0000, 1, 4'h4, 0, 16'h1234, 16'h1234, 6'b000_00_1);
    add(0, 16'h0000, 1, 4'h5, 0, 16'h2345, 16'h1234, 6'b000_00_1);
    add(0, 16'h0000, 0, 4'h0, 1, 16'h0000, 16'h1234, 6'b000_01_1);

    rstn = 1'b0;
    tick();
    check("reset", 64'(dut_vec()), 64'd0);
    rstn = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      gen = tbl[i].g; otp_in = tbl[i].otp; digit_vld = tbl[i].dv;
      digit = tbl[i].d; submit = tbl[i].sub;
      tick();
      check($sformatf("tbl[%0d]", i), 64'(dut_vec()),
            64'({tbl[i].e_user, tbl[i].e_lfsr, tbl[i].e_flags}));
    end

    // Lockout after three wrong entries; gen ignored while locked
    rstn = 1'b0; tick(); rstn = 1'b1;
    gen = 1'b1; otp_in = 16'h1234; tick();
    for (int a = 1; a <= 3; a++) begin
      enter(16'h0000);
      submit = 1'b1; tick();
      check($sformatf("lockout_att%0d", a), 64'(wrng_att), 64'(a));
      check($sformatf("lockout_lock%0d", a), 64'(lock), 64'(a == 3));
    end
    gen = 1'b1; otp_in = 16'hFFFF; tick();
    check("lock_gen_ignored", 64'({lfsr_otp, lock}), 64'({16'h1234, 1'b1}));
    for (int k = 0; k < 6; k++) begin
      tick();
      check("lock_hold", 64'(lock), 64'd1);
    end
    tick();
    check("lock_release", 64'({lock, busy, wrng_att, lfsr_otp}), 64'd0);

    // Expiry with one wrong attempt carried across the next gen
    gen = 1'b1; otp_in = 16'hAAAA; tick();
    for (int k = 1; k <= 20; k++) begin
      if (k <= 4) begin digit_vld = 1'b1; digit = 4'h0; end
      if (k == 5) submit = 1'b1;
      tick();
      check($sformatf("expire_k%0d", k), 64'(expire), 64'(k == 20));
    end
    check("expire_att", 64'(wrng_att), 64'd1);
    gen = 1'b1; otp_in = 16'h5A5A; tick();
    check("regen", 64'({expire, busy, wrng_att, lfsr_otp}), 64'({1'b0, 1'b1, 2'd1, 16'h5A5A}));

    // Correct submit on the cycle the timer reaches zero
    enter(16'h5A5A);
    for (int k = 5; k < 20; k++) tick();
    check("pre_zero", 64'({unlock, expire}), 64'd0);
    submit = 1'b1; tick();
    check("simul_unlock", 64'({unlock, expire, wrng_att}), 64'({1'b1, 1'b0, 2'd0}));

    // Reset while locked
    for (int k = 0; k < UNL_C; k++) tick();
    gen = 1'b1; otp_in = 16'h1111; tick();
    for (int a = 0; a < 3; a++) begin enter(16'h0000); submit = 1'b1; tick(); end
    tick(); tick();
    check("pre_rst_lock", 64'(lock), 64'd1);
    rstn = 1'b0; tick(); rstn = 1'b1;
    check("rst_in_lock", 64'(dut_vec()), 64'd0);
    tick();
    check("post_rst_idle", 64'(dut_vec()), 64'd0);

    // Randomized traffic against the model
    for (int i = 0; i < 4000; i++) begin
      rstn      = ($urandom_range(0, 399) != 0);
      gen       = ($urandom_range(0, 29) == 0);
      otp_in    = 16'($urandom);
      submit    = ($urandom_range(0, 5) == 0);
      digit_vld = ($urandom_range(0, 2) == 0);
      digit     = 4'($urandom);
      if (m_n < 4 && $urandom_range(0, 3) != 0) digit = m_lfsr[4*(3-m_n) +: 4];
      if (m_mode == M_ACT && cyc >= m_end) digit_vld = 1'b0;
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
